scr1_dmem_router: RTL and testbench

//  Routes single-outstanding DMEM transactions from the LSU to one of two memory ports (port1 = TCM window, port0 = everything else)
//  by address match; returns response/rdata from the port that accepted the request. Sits directly downstream of the LSU DMEM interface.

---
 rtl/scr1_dmem_router.sv | 161 ++++++++++++++++
 tb/tb_scr1_dmem_router.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/scr1_dmem_router.sv
// LSU DMEM router: steers single-outstanding transactions to port1 (TCM window) or port0.
// Optional watchdog enabled by defining SCR1_DMEM_ROUTER_TIMEOUT_EN.
module scr1_dmem_router #(
    parameter logic [31:0] SCR1_PORT1_ADDR_MASK    = 32'hFFFF_0000,
    parameter logic [31:0] SCR1_PORT1_ADDR_PATTERN = 32'h0048_0000,
    parameter int unsigned SCR1_TIMEOUT_CYCLES     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_req_i,
    input  logic        dmem_cmd_i,
    input  logic [1:0]  dmem_width_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wdata_i,
    output logic        dmem_req_ack_o,
    output logic [31:0] dmem_rdata_o,
    output logic [1:0]  dmem_resp_o,
    output logic        port0_req_o,
    output logic        port0_cmd_o,
    output logic [1:0]  port0_width_o,
    output logic [31:0] port0_addr_o,
    output logic [31:0] port0_wdata_o,
    input  logic        port0_req_ack_i,
    input  logic [31:0] port0_rdata_i,
    input  logic [1:0]  port0_resp_i,
    output logic        port1_req_o,
    output logic        port1_cmd_o,
    output logic [1:0]  port1_width_o,
    output logic [31:0] port1_addr_o,
    output logic [31:0] port1_wdata_o,
    input  logic        port1_req_ack_i,
    input  logic [31:0] port1_rdata_i,
    input  logic [1:0]  port1_resp_i
);

    localparam logic [1:0] RespIdle = 2'b00;
    localparam logic [1:0] RespOk   = 2'b01;
    localparam logic [1:0] RespEr   = 2'b10;

    if (SCR1_TIMEOUT_CYCLES < 1 || SCR1_TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("SCR1_TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic {StIdle, StWait} state_e;

    state_e      state_q, state_d;
    logic        sel_q, sel_d;
    logic        sel_comb;
    logic        blocked;
    logic        sel_ack;
    logic [1:0]  wait_resp;
    logic [31:0] wait_rdata;
    logic        port0_req, port1_req, req_ack;

    assign port0_cmd_o   = dmem_cmd_i;
    assign port0_width_o = dmem_width_i;
    assign port0_addr_o  = dmem_addr_i;
    assign port0_wdata_o = dmem_wdata_i;
    assign port1_cmd_o   = dmem_cmd_i;
    assign port1_width_o = dmem_width_i;
    assign port1_addr_o  = dmem_addr_i;
    assign port1_wdata_o = dmem_wdata_i;

    assign sel_comb   = (dmem_addr_i & SCR1_PORT1_ADDR_MASK) == SCR1_PORT1_ADDR_PATTERN;
    assign sel_ack    = sel_comb ? port1_req_ack_i : port0_req_ack_i;
    assign wait_resp  = sel_q ? port1_resp_i : port0_resp_i;
    assign wait_rdata = sel_q ? port1_rdata_i : port0_rdata_i;

    // Request-side outputs are forced low while reset is held.
    assign port0_req_o    = port0_req & ~rst;
    assign port1_req_o    = port1_req & ~rst;
    assign dmem_req_ack_o = req_ack & ~rst;

`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(SCR1_TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic [1:0] stale_q, stale_d;
    logic       timeout_hit;

    assign blocked = stale_q[sel_comb];

    // A stale port's first non-idle response only retires its stale flag.
    always_comb begin
        stale_d[0] = stale_q[0] & (port0_resp_i == RespIdle);
        stale_d[1] = stale_q[1] & (port1_resp_i == RespIdle);
        if (timeout_hit) begin
            stale_d[sel_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 8'd0;
            stale_q <= 2'b00;
        end else begin
            cnt_q   <= cnt_d;
            stale_q <= stale_d;
        end
    end
`else
    assign blocked = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        port0_req    = 1'b0;
        port1_req    = 1'b0;
        req_ack      = 1'b0;
        dmem_resp_o  = RespIdle;
        dmem_rdata_o = 32'd0;
`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_hit = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                port0_req = dmem_req_i & ~sel_comb & ~blocked;
                port1_req = dmem_req_i & sel_comb & ~blocked;
                req_ack   = sel_ack & ~blocked;
                if (dmem_req_i && req_ack) begin
                    state_d = StWait;
                    sel_d   = sel_comb;
`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end
            end
            StWait: begin
                if (wait_resp != RespIdle) begin
                    // Undefined code 2'b11 is reported as an error.
                    dmem_resp_o  = (wait_resp == RespOk) ? RespOk : RespEr;
                    dmem_rdata_o = (wait_resp == RespOk) ? wait_rdata : 32'd0;
                    state_d      = StIdle;
                end
`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
                else if (cnt_q == TimeoutLast) begin
                    dmem_resp_o = RespEr;
                    timeout_hit = 1'b1;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

endmodule

// File: tb/tb_scr1_dmem_router.sv
// Directed-vector bench for scr1_dmem_router; one record per clock cycle.
// Watchdog sequences run only when SCR1_DMEM_ROUTER_TIMEOUT_EN is defined.
module tb_scr1_dmem_router;

    typedef logic [31:0] w_t;

    typedef struct {
        w_t req; w_t cmd; w_t width; w_t addr; w_t wdata;
        w_t p0_ack; w_t p0_resp; w_t p0_rdata;
        w_t p1_ack; w_t p1_resp; w_t p1_rdata;
        w_t e_ack; w_t e_p0; w_t e_p1; w_t e_resp; w_t e_rdata;
    } vec_t;

    localparam w_t A  = 32'h0048_0010;
    localparam w_t B  = 32'h0000_2000;
    localparam int NV = 22;

    logic        clk, rst;
    logic        dmem_req, dmem_cmd;
    logic [1:0]  dmem_width;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_req_ack;
    logic [31:0] dmem_rdata;
    logic [1:0]  dmem_resp;
    logic        port0_req, port0_cmd, port1_req, port1_cmd;
    logic [1:0]  port0_width, port1_width;
    logic [31:0] port0_addr, port0_wdata, port1_addr, port1_wdata;
    logic        port0_req_ack, port1_req_ack;
    logic [31:0] port0_rdata, port1_rdata;
    logic [1:0]  port0_resp, port1_resp;

    int errors = 0;
    int checks = 0;
    vec_t tbl [NV];

    scr1_dmem_router #(
        .SCR1_TIMEOUT_CYCLES (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .dmem_req_i      (dmem_req),
        .dmem_cmd_i      (dmem_cmd),
        .dmem_width_i    (dmem_width),
        .dmem_addr_i     (dmem_addr),
        .dmem_wdata_i    (dmem_wdata),
        .dmem_req_ack_o  (dmem_req_ack),
        .dmem_rdata_o    (dmem_rdata),
        .dmem_resp_o     (dmem_resp),
        .port0_req_o     (port0_req),
        .port0_cmd_o     (port0_cmd),
        .port0_width_o   (port0_width),
        .port0_addr_o    (port0_addr),
        .port0_wdata_o   (port0_wdata),
        .port0_req_ack_i (port0_req_ack),
        .port0_rdata_i   (port0_rdata),
        .port0_resp_i    (port0_resp),
        .port1_req_o     (port1_req),
        .port1_cmd_o     (port1_cmd),
        .port1_width_o   (port1_width),
        .port1_addr_o    (port1_addr),
        .port1_wdata_o   (port1_wdata),
        .port1_req_ack_i (port1_req_ack),
        .port1_rdata_i   (port1_rdata),
        .port1_resp_i    (port1_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one record, check at the falling edge, then advance past the rising edge.
    task automatic cycle(input vec_t v, input string name);
        logic [36:0] got, exp;
        logic [69:0] cgot, cexp;
        dmem_req      = v.req[0];
        dmem_cmd      = v.cmd[0];
        dmem_width    = v.width[1:0];
        dmem_addr     = v.addr;
        dmem_wdata    = v.wdata;
        port0_req_ack = v.p0_ack[0];
        port0_resp    = v.p0_resp[1:0];
        port0_rdata   = v.p0_rdata;
        port1_req_ack = v.p1_ack[0];
        port1_resp    = v.p1_resp[1:0];
        port1_rdata   = v.p1_rdata;
        @(negedge clk);
        got = {dmem_req_ack, port0_req, port1_req, dmem_resp, dmem_rdata};
        exp = {v.e_ack[0], v.e_p0[0], v.e_p1[0], v.e_resp[1:0], v.e_rdata};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: ack/p0req/p1req/resp/rdata got %b/%b/%b/%b/%h required %b/%b/%b/%b/%h",
                     name, got[36], got[35], got[34], got[33:32], got[31:0],
                     exp[36], exp[35], exp[34], exp[33:32], exp[31:0]);
        end
        cgot = {port0_cmd, port0_width, port0_addr, port1_cmd, port1_width, port1_addr};
        cexp = {v.cmd[0], v.width[1:0], v.addr, v.cmd[0], v.width[1:0], v.addr};
        checks++;
        if (cgot !== cexp || port0_wdata !== v.wdata || port1_wdata !== v.wdata) begin
            errors++;
            $display("FAIL %s_copy: port fields got %h wdata %h/%h required %h wdata %h",
                     name, cgot, port0_wdata, port1_wdata, cexp, v.wdata);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        //        req cmd w  addr wdata   p0ack resp rdata   p1ack resp rdata   eack ep0 ep1 eresp erdata
        tbl[0]  = '{1, 0, 2, A, 0,        0, 0, 0,           1, 1, 32'h1111,     1, 0, 1, 0, 0};
        tbl[1]  = '{0, 0, 2, A, 0,        0, 0, 0,           0, 0, 0,            0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 2, A, 0,        0, 0, 0,           0, 0, 0,            0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 2, A, 0,        0, 0, 0,           0, 1, 32'hDEADBEEF, 0, 0, 0, 1, 32'hDEADBEEF};
        tbl[4]  = '{0, 0, 2, A, 0,        0, 0, 0,           0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0};
        tbl[5]  = '{1, 1, 2, B, 32'h12345678, 0, 0, 0,       0, 0, 0,            0, 1, 0, 0, 0};
        tbl[6]  = '{1, 1, 2, B, 32'h12345678, 0, 0, 0,       0, 0, 0,            0, 1, 0, 0, 0};
        tbl[7]  = '{1, 1, 2, B, 32'h12345678, 1, 0, 0,       0, 0, 0,            1, 1, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, B, 0,        0, 0, 0,           0, 1, 32'hAAAA5555, 0, 0, 0, 0, 0};
        tbl[9]  = '{1, 0, 2, A, 0,        0, 2, 32'h5555AAAA, 1, 0, 0,           0, 0, 0, 2, 0};
        tbl[10] = '{1, 0, 2, A, 0,        0, 0, 0,           1, 0, 0,            1, 0, 1, 0, 0};
        tbl[11] = '{0, 0, 2, A, 0,        0, 0, 0,           0, 3, 32'h77,       0, 0, 0, 2, 0};
        tbl[12] = '{1, 0, 1, B, 0,        1, 0, 0,           0, 0, 0,            1, 1, 0, 0, 0};
        tbl[13] = '{0, 0, 1, B, 0,        0, 1, 32'hCAFEF00D, 0, 0, 0,           0, 0, 0, 1, 32'hCAFEF00D};
        tbl[14] = '{0, 0, 0, B, 0,        0, 1, 32'h01020304, 0, 0, 0,           0, 0, 0, 0, 0};
        tbl[15] = '{1, 0, 2, 32'h0048FFFC, 0, 1, 0, 0,       1, 0, 0,            1, 0, 1, 0, 0};
        tbl[16] = '{0, 0, 2, 32'h0048FFFC, 0, 0, 0, 0,       0, 1, 32'h0BADF00D, 0, 0, 0, 1, 32'h0BADF00D};
        tbl[17] = '{1, 0, 0, 32'h00490000, 0, 0, 0, 0,       1, 0, 0,            0, 1, 0, 0, 0};
        tbl[18] = '{1, 0, 0, 32'h00490000, 0, 1, 0, 0,       1, 0, 0,            1, 1, 0, 0, 0};
        tbl[19] = '{0, 0, 0, 32'h00490000, 0, 0, 1, 32'h13579BDF, 0, 0, 0,       0, 0, 0, 1, 32'h13579BDF};
        tbl[20] = '{1, 0, 0, 32'h0047FFFF, 0, 1, 0, 0,       0, 0, 0,            1, 1, 0, 0, 0};
        tbl[21] = '{0, 0, 0, 32'h0047FFFF, 0, 0, 1, 32'h2468ACE0, 0, 0, 0,       0, 0, 0, 1, 32'h2468ACE0};

        rst = 1'b1;
        cycle('{1, 0, 2, A, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0}, "reset_outputs");
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            cycle(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset in WAIT, then a late port0 reply must be dropped.
        cycle('{1, 1, 2, B, 32'h55, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0}, "rst_seq_req");
        rst = 1'b1;
        cycle('{0, 0, 2, B, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, "rst_in_wait");
        rst = 1'b0;
        cycle('{0, 0, 2, B, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, "rst_rel1");
        cycle('{0, 0, 2, B, 0, 0, 1, 32'hFEEDFACE, 0, 0, 0, 0, 0, 0, 0, 0}, "rst_late_drop");
        cycle('{1, 0, 2, A, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0}, "post_rst_req");
        cycle('{0, 0, 2, A, 0, 0, 0, 0, 0, 1, 32'h600DCAFE, 0, 0, 0, 1, 32'h600DCAFE},
              "post_rst_resp");

`ifdef SCR1_DMEM_ROUTER_TIMEOUT_EN
        // Port1 silent for 4 WAIT cycles, then held off until its late reply is drained.
        cycle('{1, 0, 2, A, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0}, "to_req");
        for (int i = 1; i <= 3; i++) begin
            cycle('{0, 0, 2, A, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, $sformatf("to_wait%0d", i));
        end
        cycle('{0, 0, 2, A, 0, 0, 0, 0, 0, 0, 32'h99, 0, 0, 0, 2, 0}, "to_fire");
        cycle('{1, 0, 2, A, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0}, "to_blocked");
        cycle('{1, 1, 2, B, 32'h42, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0}, "to_port0_req");
        cycle('{0, 0, 2, B, 0, 0, 1, 32'h31415926, 0, 0, 0, 0, 0, 0, 1, 32'h31415926},
              "to_port0_resp");
        cycle('{1, 0, 2, A, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0}, "to_still_blocked");
        cycle('{0, 0, 2, A, 0, 0, 0, 0, 0, 1, 32'h0BADBAD0, 0, 0, 0, 0, 0}, "to_swallow");
        cycle('{1, 0, 2, A, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0}, "to_unblocked");
        cycle('{0, 0, 2, A, 0, 0, 0, 0, 0, 1, 32'h12121212, 0, 0, 0, 1, 32'h12121212},
              "to_after");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
